// File: rtl/cmd_issue.sv
// Command issue stage: FIFO-buffered custom-0 instructions issued to commit,
// one outstanding request at a time, with counters and sticky error flags.
module cmd_issue #(
  parameter int         DEPTH   = 16,
  parameter int         AW      = 4,
  parameter int         TIMEOUT = 4096,
  parameter logic [6:0] OPCODE  = 7'b0001011
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  output logic        full,
  output logic        empty,
  input  logic        enable,
  input  logic        soft_clr,
  output logic        req_vaild,
  input  logic        req_ready,
  output logic [31:0] r_in,
  input  logic        rsp_vaild,
  output logic        rsp_ready,
  output logic        busy,
  output logic [31:0] issued_cnt,
  output logic [31:0] done_cnt,
  output logic [7:0]  drop_cnt,
  output logic        ovf,
  output logic        tmo
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RSP
  } state_t;

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST =
    (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
  localparam logic [TW-1:0] T1 = TW'(1);
  localparam logic [AW-1:0] P1 = AW'(1);
  localparam logic [AW:0]   C1 = (AW + 1)'(1);
  localparam logic [AW:0]   CFULL = (AW + 1)'(DEPTH);

  state_t state, state_nxt;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   cnt, cnt_nxt;
  logic [31:0]   head;
  logic [TW-1:0] tcnt;
  logic push, pop, hit, drop;
  logic req_fire, rsp_fire, tmo_fire;

  assign head     = mem[rptr];
  assign hit      = head[6:0] == OPCODE;
  assign push     = wr_en && !full && !soft_clr;
  assign pop      = (state == IDLE) && enable && !empty && !soft_clr;
  assign drop     = pop && !hit;
  assign req_fire = (state == REQ) && req_ready;
  assign rsp_fire = (state == RSP) && rsp_vaild;
  // A response arriving on the last allowed cycle wins over the timeout.
  assign tmo_fire = (TIMEOUT != 0) && (state == RSP) &&
                    !rsp_vaild && (tcnt == TLAST);

  assign req_vaild = state == REQ;
  assign rsp_ready = state == RSP;
  assign busy      = state != IDLE;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (pop && hit) state_nxt = REQ;
      REQ:     if (req_ready) state_nxt = RSP;
      RSP:     if (rsp_vaild || tmo_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cnt_nxt = cnt;
    if (push && !pop)      cnt_nxt = cnt + C1;
    else if (pop && !push) cnt_nxt = cnt - C1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt   <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else if (soft_clr) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt   <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (push) wptr <= wptr + P1;
      if (pop)  rptr <= rptr + P1;
      cnt   <= cnt_nxt;
      full  <= cnt_nxt == CFULL;
      empty <= cnt_nxt == '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_in <= '0;
      tcnt <= '0;
    end else begin
      if (pop && hit) r_in <= head;
      if (req_fire) tcnt <= '0;
      else if ((state == RSP) && !rsp_vaild) tcnt <= tcnt + T1;
    end
  end

  // In-flight completions land on top of a same-cycle clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issued_cnt <= '0;
      done_cnt   <= '0;
      drop_cnt   <= '0;
      ovf        <= 1'b0;
      tmo        <= 1'b0;
    end else begin
      issued_cnt <= (soft_clr ? '0 : issued_cnt) + 32'(req_fire);
      done_cnt   <= (soft_clr ? '0 : done_cnt) + 32'(rsp_fire);
      if (soft_clr)
        drop_cnt <= '0;
      else if (drop && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
      ovf <= !soft_clr && (ovf || (wr_en && full));
      tmo <= tmo_fire || (!soft_clr && tmo);
    end
  end

endmodule

// File: doc/cmd_issue.md
Name: cmd_issue

Overview:
- Command issue stage directly upstream of the commit block.
- Buffers 32-bit custom-0 instructions (opcode[6:0] = 7'b0001011) from a host or loader in a FIFO.
- Issues them one at a time on commit's req channel (req_vaild/req_ready/r_in), then consumes the matching response on the rsp channel (rsp_vaild/rsp_ready).
- Strictly one instruction outstanding. Keeps issue/completion/drop counters and sticky error flags.

Parameters:
- DEPTH, 16, FIFO entries (power of 2, ≥2).
- AW, 4, FIFO pointer width; log2(DEPTH).
- TIMEOUT, 4096, max cycles waiting for rsp_vaild; 0 disables the timeout.
- OPCODE, 7'b0001011, accepted opcode value for bits [6:0].

Ports:
- clk  in  1  single clock; commit's clk_150_0 domain.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  push wr_data into FIFO.
- wr_data  in  32  instruction to enqueue.
- full  out  1  FIFO full.
- empty  out  1  FIFO empty.
- enable  in  1  level; allows popping new instructions.
- soft_clr  in  1  one-cycle synchronous flush of FIFO, counters and flags.
- req_vaild  out  1  request valid to commit.
- req_ready  in  1  commit accepts the request.
- r_in  out  32  instruction to commit; connects to commit r_in.
- rsp_vaild  in  1  commit response valid.
- rsp_ready  out  1  issuer ready for the response.
- busy  out  1  state != IDLE.
- issued_cnt  out  32  requests accepted by commit.
- done_cnt  out  32  responses consumed.
- drop_cnt  out  8  bad-opcode entries discarded; saturates at 255.
- ovf  out  1  sticky: push attempted while full.
- tmo  out  1  sticky: response timeout occurred.

Behaviour:
- Reset (reset=0, async): all outputs 0 except empty=1; r_in=0; FIFO pointers 0; state IDLE; timeout counter 0.
- FIFO push: wr_en && !full writes at wptr, wptr+1 with wrap mod DEPTH.
- Push while full is dropped and sets ovf. A same-cycle pop does not make room; full blocks regardless.
- full/empty are registered. A push at cycle t makes empty=0 at t+1.
- FSM states: IDLE, REQ, RSP.
- IDLE: if enable && !empty, pop the head at this edge.
  - If head[6:0] != OPCODE: drop_cnt++ (saturating), stay in IDLE. Costs 1 cycle per dropped entry.
  - Otherwise r_in<=head, req_vaild<=1, go to REQ.
- Latency: first push to req_vaild is 2 cycles (push t, pop t+1, req_vaild high from t+2).
- REQ: req_vaild and r_in are held stable until req_ready=1. On that edge: req_vaild<=0, issued_cnt++, rsp_ready<=1, timeout counter<=0, go to RSP.
- RSP: rsp_ready is held high. A transfer is rsp_vaild && rsp_ready. On transfer: rsp_ready<=0, done_cnt++, go to IDLE.
- Earliest next req_vaild after a response is 2 cycles later (IDLE pop cycle intervenes).
- Timeout (TIMEOUT>0): the counter increments each RSP cycle without rsp_vaild. On reaching TIMEOUT-1 without a response: rsp_ready<=0, tmo<=1, go to IDLE.
  - A late rsp_vaild is then ignored (rsp_ready=0), and done_cnt is not incremented.
  - rsp_vaild and the timeout in the same cycle: the response wins.
- enable deassert: an in-flight transaction completes normally; no new pop occurs.
- soft_clr: clears pointers (empty=1, full=0), all counters and ovf/tmo.
  - It does not abort REQ/RSP; the in-flight transaction finishes, and its counter increment is applied after the clear.
  - soft_clr && wr_en in the same cycle: the clear wins and the push is discarded.
- rsp_vaild in IDLE or REQ is ignored; rsp_ready=0 there.
- issued_cnt and done_cnt wrap modulo 2^32.
- Invariant: issued_cnt - done_cnt ∈ {0,1}, excluding timeouts.

Test Plan:
- Basic path: push 0x0400010B, enable=1, commit asserts req_ready 3 cycles after req_vaild and rsp_vaild 5 cycles later -> r_in=0x0400010B stable through the handshake; issued_cnt=1, done_cnt=1; busy=0; empty=1.
- Back-to-back: push 13 valid instructions, req_ready and rsp_vaild tied high -> 13 requests issued in FIFO order, each req_vaild 2 cycles after the previous response; done_cnt=13.
- Bad opcode: push 0x00000013 then 0x0400010B -> drop_cnt=1; only 0x0400010B appears on r_in; issued_cnt=1.
- Overflow: push 17 entries with enable=0, DEPTH=16 -> full=1 after 16, ovf=1; a later drain issues exactly 16 instructions.
- Timeout: TIMEOUT=8, rsp_vaild never asserted -> rsp_ready falls after 8 RSP cycles; tmo=1, done_cnt=0, state IDLE. A next queued instruction still issues.
- Reset/clear: async reset=0 during RSP -> req_vaild=0, rsp_ready=0 and all counters 0 immediately. soft_clr with 5 queued entries -> empty=1 next cycle and counters 0.
